// File: rtl/stream_boot_ctrl_if.sv
// Link, memory and core handshake bundle for the boot controller.
// master = controller side, slave = host/memory/core side.
interface stream_boot_ctrl_if #(
    parameter int DATAW          = 32,
    parameter int INST_MEM_ADDRW = 12,
    parameter int CACHE_ADDRW    = 16
);
    logic [7:0]                rx_data;
    logic                      rx_valid;
    logic                      rx_ready;
    logic [7:0]                tx_data;
    logic                      tx_valid;
    logic                      tx_ready;
    logic                      cache_init_done;
    logic                      instr_we;
    logic [INST_MEM_ADDRW-1:0] instr_addr;
    logic [DATAW-1:0]          instr_data;
    logic                      cache_we;
    logic                      cache_re;
    logic [CACHE_ADDRW-1:0]    cache_addr;
    logic [DATAW-1:0]          cache_wdata;
    logic                      cache_wready;
    logic [DATAW-1:0]          cache_rdata;
    logic                      cache_valid;
    logic                      core_exec_done;
    logic [CACHE_ADDRW:0]      result_words;
    logic                      core_clk_en;
    logic                      err;

    modport master (
        input  rx_data, rx_valid, tx_ready, cache_init_done, cache_wready,
               cache_rdata, cache_valid, core_exec_done, result_words,
        output rx_ready, tx_data, tx_valid, instr_we, instr_addr, instr_data,
               cache_we, cache_re, cache_addr, cache_wdata, core_clk_en, err
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, cache_init_done, cache_wready,
               cache_rdata, cache_valid, core_exec_done, result_words,
        input  rx_ready, tx_data, tx_valid, instr_we, instr_addr, instr_data,
               cache_we, cache_re, cache_addr, cache_wdata, core_clk_en, err
    );
endinterface

// File: rtl/stream_boot_ctrl.sv
// Boot controller: loads length-prefixed instruction/data images from the byte
// link, verifies a byte checksum, runs the core and streams back the result region.
module stream_boot_ctrl #(
    parameter int DATAW          = 32,
    parameter int INST_MEM_ADDRW = 12,
    parameter int CACHE_ADDRW    = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    stream_boot_ctrl_if.master io_link
);
    localparam int BPW  = DATAW / 8;
    localparam int IDXW = ((INST_MEM_ADDRW > CACHE_ADDRW) ? INST_MEM_ADDRW : CACHE_ADDRW) + 1;
    localparam int BCW  = $clog2(BPW + 4) + 1;
    localparam logic [BCW-1:0] LAST_WBYTE = BCW'(BPW - 1);
    localparam logic [BCW-1:0] LAST_CBYTE = BCW'(3);
    localparam logic [32:0]    I_LIMIT    = 33'd1 << INST_MEM_ADDRW;
    localparam logic [32:0]    D_LIMIT    = 33'd1 << CACHE_ADDRW;
    localparam logic [7:0]     TOK_RDY    = 8'h99;
    localparam logic [7:0]     TOK_ACK    = 8'haa;
    localparam logic [7:0]     TOK_END    = 8'h55;
    localparam logic [7:0]     TOK_ERR    = 8'hee;

    typedef enum logic [3:0] {
        ST_INIT, ST_SEND_RDY, ST_RX_ICNT, ST_RX_IWORD, ST_RX_DCNT, ST_RX_DWORD,
        ST_DWRITE, ST_RX_CSUM, ST_SEND_ACK, ST_RUN, ST_DUMP_WAIT, ST_DUMP_TX,
        ST_SEND_END, ST_DONE, ST_SEND_ERR, ST_ERR
    } state_t;

    state_t                    r_state;
    logic                      r_rx_ready;
    logic                      r_tx_valid;
    logic [7:0]                r_tx_data;
    logic                      r_instr_we;
    logic [INST_MEM_ADDRW-1:0] r_instr_addr;
    logic [DATAW-1:0]          r_instr_data;
    logic                      r_cache_we;
    logic                      r_cache_re;
    logic [CACHE_ADDRW-1:0]    r_cache_addr;
    logic [DATAW-1:0]          r_cache_wdata;
    logic                      r_core_clk_en;
    logic                      r_err;
    logic [31:0]               r_cnt;
    logic [DATAW-1:0]          r_shift;
    logic [BCW-1:0]            r_bcnt;
    logic [IDXW-1:0]           r_idx;
    logic [IDXW-1:0]           r_total;
    logic [7:0]                r_csum;

    logic                      w_rx_fire;
    logic                      w_tx_fire;
    logic [31:0]               w_cnt;
    logic [DATAW-1:0]          w_word;
    logic [DATAW-1:0]          w_shift_nx;
    logic [IDXW-1:0]           w_idx_inc;
    logic                      w_idx_last;

    // Bytes arrive LSB first, so each new byte enters at the top of the shifter.
    assign w_rx_fire  = r_rx_ready & io_link.rx_valid;
    assign w_tx_fire  = r_tx_valid & io_link.tx_ready;
    assign w_cnt      = {io_link.rx_data, r_cnt[31:8]};
    assign w_word     = (r_shift >> 8) | (DATAW'(io_link.rx_data) << (DATAW - 8));
    assign w_shift_nx = r_shift >> 8;
    assign w_idx_inc  = r_idx + IDXW'(1);
    assign w_idx_last = (w_idx_inc == r_total);

    // Boot sequencer with all outputs registered.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state       <= ST_INIT;
            r_rx_ready    <= 1'b0;
            r_tx_valid    <= 1'b0;
            r_tx_data     <= 8'h00;
            r_instr_we    <= 1'b0;
            r_instr_addr  <= {INST_MEM_ADDRW{1'b0}};
            r_instr_data  <= {DATAW{1'b0}};
            r_cache_we    <= 1'b0;
            r_cache_re    <= 1'b0;
            r_cache_addr  <= {CACHE_ADDRW{1'b0}};
            r_cache_wdata <= {DATAW{1'b0}};
            r_core_clk_en <= 1'b0;
            r_err         <= 1'b0;
            r_cnt         <= 32'h0;
            r_shift       <= {DATAW{1'b0}};
            r_bcnt        <= {BCW{1'b0}};
            r_idx         <= {IDXW{1'b0}};
            r_total       <= {IDXW{1'b0}};
            r_csum        <= 8'h00;
        end else begin
            r_instr_we <= 1'b0;
            r_cache_re <= 1'b0;
            if (w_rx_fire && (r_state != ST_RX_CSUM)) begin
                r_csum <= r_csum + io_link.rx_data;
            end
            case (r_state)
                ST_INIT: begin
                    if (io_link.cache_init_done) begin
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= TOK_RDY;
                        r_state    <= ST_SEND_RDY;
                    end
                end
                ST_SEND_RDY: begin
                    if (w_tx_fire) begin
                        r_tx_valid <= 1'b0;
                        r_rx_ready <= 1'b1;
                        r_bcnt     <= {BCW{1'b0}};
                        r_idx      <= {IDXW{1'b0}};
                        r_csum     <= 8'h00;
                        r_state    <= ST_RX_ICNT;
                    end
                end
                ST_RX_ICNT, ST_RX_DCNT: begin
                    if (w_rx_fire) begin
                        r_cnt  <= w_cnt;
                        r_bcnt <= r_bcnt + BCW'(1);
                        if (r_bcnt == LAST_CBYTE) begin
                            r_bcnt  <= {BCW{1'b0}};
                            r_idx   <= {IDXW{1'b0}};
                            r_total <= IDXW'(w_cnt);
                            if (33'(w_cnt) > ((r_state == ST_RX_ICNT) ? I_LIMIT : D_LIMIT)) begin
                                r_rx_ready <= 1'b0;
                                r_err      <= 1'b1;
                                r_tx_valid <= 1'b1;
                                r_tx_data  <= TOK_ERR;
                                r_state    <= ST_SEND_ERR;
                            end else if (r_state == ST_RX_ICNT) begin
                                r_state <= (w_cnt == 32'h0) ? ST_RX_DCNT : ST_RX_IWORD;
                            end else begin
                                r_state <= (w_cnt == 32'h0) ? ST_RX_CSUM : ST_RX_DWORD;
                            end
                        end
                    end
                end
                ST_RX_IWORD: begin
                    if (w_rx_fire) begin
                        r_shift <= w_word;
                        r_bcnt  <= r_bcnt + BCW'(1);
                        if (r_bcnt == LAST_WBYTE) begin
                            r_bcnt       <= {BCW{1'b0}};
                            r_instr_we   <= 1'b1;
                            r_instr_addr <= r_idx[INST_MEM_ADDRW-1:0];
                            r_instr_data <= w_word;
                            r_idx        <= w_idx_last ? {IDXW{1'b0}} : w_idx_inc;
                            r_state      <= w_idx_last ? ST_RX_DCNT : ST_RX_IWORD;
                        end
                    end
                end
                ST_RX_DWORD: begin
                    if (w_rx_fire) begin
                        r_shift <= w_word;
                        r_bcnt  <= r_bcnt + BCW'(1);
                        if (r_bcnt == LAST_WBYTE) begin
                            r_bcnt        <= {BCW{1'b0}};
                            r_rx_ready    <= 1'b0;
                            r_cache_we    <= 1'b1;
                            r_cache_addr  <= r_idx[CACHE_ADDRW-1:0];
                            r_cache_wdata <= w_word;
                            r_state       <= ST_DWRITE;
                        end
                    end
                end
                ST_DWRITE: begin
                    if (io_link.cache_wready) begin
                        r_cache_we <= 1'b0;
                        r_rx_ready <= 1'b1;
                        r_idx      <= w_idx_last ? {IDXW{1'b0}} : w_idx_inc;
                        r_state    <= w_idx_last ? ST_RX_CSUM : ST_RX_DWORD;
                    end
                end
                ST_RX_CSUM: begin
                    if (w_rx_fire) begin
                        r_rx_ready <= 1'b0;
                        r_tx_valid <= 1'b1;
                        if (io_link.rx_data == r_csum) begin
                            r_tx_data <= TOK_ACK;
                            r_state   <= ST_SEND_ACK;
                        end else begin
                            r_err     <= 1'b1;
                            r_tx_data <= TOK_ERR;
                            r_state   <= ST_SEND_ERR;
                        end
                    end
                end
                ST_SEND_ACK: begin
                    if (w_tx_fire) begin
                        r_tx_valid    <= 1'b0;
                        r_core_clk_en <= 1'b1;
                        r_state       <= ST_RUN;
                    end
                end
                // The first read is issued on the same edge the core stops, so they never overlap.
                ST_RUN: begin
                    if (io_link.core_exec_done) begin
                        r_core_clk_en <= 1'b0;
                        r_total       <= IDXW'(io_link.result_words);
                        r_idx         <= {IDXW{1'b0}};
                        if (io_link.result_words == {(CACHE_ADDRW + 1){1'b0}}) begin
                            r_tx_valid <= 1'b1;
                            r_tx_data  <= TOK_END;
                            r_state    <= ST_SEND_END;
                        end else begin
                            r_cache_re   <= 1'b1;
                            r_cache_addr <= {CACHE_ADDRW{1'b0}};
                            r_state      <= ST_DUMP_WAIT;
                        end
                    end
                end
                ST_DUMP_WAIT: begin
                    if (io_link.cache_valid && !r_cache_re) begin
                        r_shift    <= io_link.cache_rdata;
                        r_tx_data  <= io_link.cache_rdata[7:0];
                        r_tx_valid <= 1'b1;
                        r_bcnt     <= {BCW{1'b0}};
                        r_state    <= ST_DUMP_TX;
                    end
                end
                ST_DUMP_TX: begin
                    if (w_tx_fire) begin
                        if (r_bcnt == LAST_WBYTE) begin
                            r_bcnt <= {BCW{1'b0}};
                            if (w_idx_last) begin
                                r_tx_data <= TOK_END;
                                r_state   <= ST_SEND_END;
                            end else begin
                                r_tx_valid   <= 1'b0;
                                r_idx        <= w_idx_inc;
                                r_cache_re   <= 1'b1;
                                r_cache_addr <= w_idx_inc[CACHE_ADDRW-1:0];
                                r_state      <= ST_DUMP_WAIT;
                            end
                        end else begin
                            r_bcnt    <= r_bcnt + BCW'(1);
                            r_shift   <= w_shift_nx;
                            r_tx_data <= w_shift_nx[7:0];
                        end
                    end
                end
                ST_SEND_END: begin
                    if (w_tx_fire) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= ST_DONE;
                    end
                end
                ST_SEND_ERR: begin
                    if (w_tx_fire) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= ST_ERR;
                    end
                end
                ST_DONE, ST_ERR: begin
                    r_state <= r_state;
                end
                default: begin
                    r_rx_ready    <= 1'b0;
                    r_tx_valid    <= 1'b0;
                    r_cache_we    <= 1'b0;
                    r_core_clk_en <= 1'b0;
                    r_state       <= ST_INIT;
                end
            endcase
        end
    end

    assign io_link.rx_ready    = r_rx_ready;
    assign io_link.tx_valid    = r_tx_valid;
    assign io_link.tx_data     = r_tx_data;
    assign io_link.instr_we    = r_instr_we;
    assign io_link.instr_addr  = r_instr_addr;
    assign io_link.instr_data  = r_instr_data;
    assign io_link.cache_we    = r_cache_we;
    assign io_link.cache_re    = r_cache_re;
    assign io_link.cache_addr  = r_cache_addr;
    assign io_link.cache_wdata = r_cache_wdata;
    assign io_link.core_clk_en = r_core_clk_en;
    assign io_link.err         = r_err;
endmodule

// File: tb/tb_stream_boot_ctrl.sv
// Directed bench for stream_boot_ctrl: host/memory/core models with scoreboard
// queues for tx bytes, instruction writes and data-cache writes.
module tb_stream_boot_ctrl;
    localparam int DATAW = 32;
    localparam int IAW   = 12;
    localparam int CAW   = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    stream_boot_ctrl_if #(.DATAW(DATAW), .INST_MEM_ADDRW(IAW), .CACHE_ADDRW(CAW)) link ();

    stream_boot_ctrl #(.DATAW(DATAW), .INST_MEM_ADDRW(IAW), .CACHE_ADDRW(CAW)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_link(link)
    );

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  q_tx[$];
    logic [43:0] q_iw[$];
    logic [47:0] q_cw[$];
    logic [31:0] img_i[$];
    logic [31:0] img_d[$];
    logic [31:0] mem[0:15];
    logic [7:0]  tb_csum;
    int          n_iwe = 0;
    int          wdelay = 0;
    int          wstall = 0;
    int          rlat = 1;
    int          rd_next = 0;
    bit          tx_toggle = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] outs();
        return 128'({link.rx_ready, link.tx_data, link.tx_valid, link.instr_we, link.instr_addr,
                     link.instr_data, link.cache_we, link.cache_re, link.cache_addr,
                     link.cache_wdata, link.core_clk_en, link.err});
    endfunction

    // Host sink readiness: always ready, or toggling every cycle.
    initial begin
        link.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            link.tx_ready = tx_toggle ? ~link.tx_ready : 1'b1;
        end
    end

    // Tx scoreboard: every handshaken byte must match the next expected byte.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (rst && link.tx_valid && link.tx_ready) begin
                e = (q_tx.size() != 0) ? {1'b0, q_tx.pop_front()} : 9'h100;
                chk("tx_byte", 128'({1'b0, link.tx_data}), 128'(e));
            end
        end
    end

    // Instruction/cache-side models and overlap check.
    initial begin
        logic [44:0] ei;
        logic [48:0] ec;
        logic [15:0] rd_addr;
        int          rd_cnt;
        bit          rd_pend;
        rd_pend = 1'b0;
        rd_cnt  = 0;
        rd_addr = 16'h0;
        link.cache_wready = 1'b0;
        link.cache_valid  = 1'b0;
        link.cache_rdata  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (link.instr_we) begin
                n_iwe++;
                ei = (q_iw.size() != 0) ? {1'b0, q_iw.pop_front()} : {1'b1, 44'h0};
                chk("instr_wr", 128'({1'b0, link.instr_addr, link.instr_data}), 128'(ei));
            end
            if (link.core_clk_en) begin
                chk("clk_en_overlap", 128'({link.instr_we, link.cache_we, link.cache_re}), 128'(0));
            end
            link.cache_wready = 1'b0;
            if (link.cache_we) begin
                if (wstall >= wdelay) begin
                    ec = (q_cw.size() != 0) ? {1'b0, q_cw.pop_front()} : {1'b1, 48'h0};
                    chk("cache_wr", 128'({1'b0, link.cache_addr, link.cache_wdata}), 128'(ec));
                    link.cache_wready = 1'b1;
                    wstall = 0;
                end else begin
                    wstall++;
                end
            end
            link.cache_valid = 1'b0;
            if (rd_pend) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    link.cache_valid = 1'b1;
                    link.cache_rdata = mem[rd_addr[3:0]];
                    rd_pend = 1'b0;
                end
            end
            if (link.cache_re) begin
                chk("cache_raddr", 128'(link.cache_addr), 128'(rd_next));
                rd_next++;
                rd_addr = link.cache_addr;
                rd_pend = 1'b1;
                rd_cnt  = rlat;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        link.rx_data  = b;
        link.rx_valid = 1'b1;
        tb_csum = tb_csum + b;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (link.rx_ready) break;
        end
        if (!link.rx_ready) chk("rx_accept_timeout", 128'(link.rx_ready), 128'(1));
        @(posedge clk);
        #1;
        link.rx_valid = 1'b0;
    endtask

    task automatic send_word32(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic wait_tx_empty(input int budget);
        for (int n = 0; n < budget; n++) begin
            if (q_tx.size() == 0 && !link.tx_valid) break;
            @(posedge clk);
            #1;
        end
        chk("tx_drain", 128'({link.tx_valid, 32'(q_tx.size())}), 128'(0));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        link.rx_valid = 1'b0;
        link.rx_data = 8'h00;
        link.core_exec_done = 1'b0;
        link.result_words = 17'h0;
        link.cache_init_done = 1'b0;
        tb_csum = 8'h00;
        n_iwe = 0;
        wstall = 0;
        rd_next = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", outs(), 128'(0));
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("init_waits", 128'(link.tx_valid), 128'(0));
        q_tx.push_back(8'h99);
        link.cache_init_done = 1'b1;
        wait_tx_empty(50);
    endtask

    task automatic load_image(input logic [7:0] csum_off, input logic [7:0] reply);
        logic [7:0] v;
        send_word32(32'(img_i.size()));
        foreach (img_i[k]) begin
            q_iw.push_back({12'(k), img_i[k]});
            send_word32(img_i[k]);
        end
        send_word32(32'(img_d.size()));
        foreach (img_d[k]) begin
            q_cw.push_back({16'(k), img_d[k]});
            send_word32(img_d[k]);
        end
        v = tb_csum + csum_off;
        q_tx.push_back(reply);
        send_byte(v);
        wait_tx_empty(500);
        chk("iw_all_written", 128'(q_iw.size()), 128'(0));
        chk("cw_all_written", 128'(q_cw.size()), 128'(0));
    endtask

    task automatic run_dump(input int r);
        link.result_words = 17'(r);
        for (int k = 0; k < r; k++)
            for (int b = 0; b < 4; b++) q_tx.push_back(mem[k][8*b +: 8]);
        q_tx.push_back(8'h55);
        link.core_exec_done = 1'b1;
        @(posedge clk);
        #1;
        link.core_exec_done = 1'b0;
        chk("core_clk_en_off", 128'(link.core_clk_en), 128'(0));
        wait_tx_empty(800);
        chk("reads_issued", 128'(rd_next), 128'(r));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Nominal load, run and one-word dump.
        do_reset();
        img_i = '{32'h00000013, 32'h00100093};
        img_d = '{32'hdeadbeef};
        load_image(8'h00, 8'haa);
        repeat (3) @(posedge clk);
        #1;
        chk("core_clk_en_on", 128'(link.core_clk_en), 128'(1));
        chk("rx_ready_in_run", 128'(link.rx_ready), 128'(0));
        mem[0] = 32'h11223344;
        run_dump(1);
        chk("nominal_err", 128'(link.err), 128'(0));

        // Checksum off by one.
        do_reset();
        load_image(8'h01, 8'hee);
        chk("csum_err", 128'({link.err, link.core_clk_en}), 128'(2'b10));
        link.core_exec_done = 1'b1;
        link.rx_data = 8'h12;
        link.rx_valid = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            for (int n = 0; n < 8; n++) begin
                @(negedge clk);
                seen = seen | link.rx_ready | link.core_clk_en | link.tx_valid;
            end
            chk("err_state_quiet", 128'(seen), 128'(0));
        end
        link.rx_valid = 1'b0;
        link.core_exec_done = 1'b0;

        // Empty images, empty result.
        do_reset();
        img_i = {};
        img_d = {};
        load_image(8'h00, 8'haa);
        chk("empty_run", 128'(link.core_clk_en), 128'(1));
        run_dump(0);

        // Slow cache writes, toggling tx_ready, multi-word dump.
        do_reset();
        wdelay = 5;
        rlat = 3;
        tx_toggle = 1'b1;
        img_i = '{32'hcafe0001};
        img_d = '{32'h01020304, 32'ha5a55a5a, 32'hffffff00};
        load_image(8'h00, 8'haa);
        mem[0] = 32'h89abcdef;
        mem[1] = 32'h00ff00ff;
        mem[2] = 32'h76543210;
        run_dump(3);
        tx_toggle = 1'b0;
        wdelay = 0;
        rlat = 1;

        // Instruction count one past full depth.
        do_reset();
        q_tx.push_back(8'hee);
        send_word32(32'h00001001);
        wait_tx_empty(50);
        chk("icnt_over_err", 128'({link.err, link.rx_ready}), 128'(2'b10));
        chk("icnt_over_no_we", 128'(n_iwe), 128'(0));

        // Full-depth instruction count is accepted.
        do_reset();
        send_word32(32'h00001000);
        repeat (4) @(posedge clk);
        #1;
        chk("icnt_full_ok", 128'({link.err, link.rx_ready, link.tx_valid}), 128'(3'b010));

        // Data count one past full depth.
        do_reset();
        send_word32(32'h0);
        q_tx.push_back(8'hee);
        send_word32(32'h00010001);
        wait_tx_empty(50);
        chk("dcnt_over_err", 128'(link.err), 128'(1));

        // Reset mid-word, then full reload.
        do_reset();
        send_word32(32'h1);
        send_byte(8'h11);
        send_byte(8'h22);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("midword_reset_outputs", outs(), 128'(0));
        chk("midword_no_we", 128'(n_iwe), 128'(0));
        do_reset();
        img_i = '{32'h00000013, 32'h00100093};
        img_d = '{32'hdeadbeef};
        load_image(8'h00, 8'haa);
        chk("reload_we_count", 128'(n_iwe), 128'(2));
        mem[0] = 32'h0badf00d;
        run_dump(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stream_boot_ctrl.md
# stream_boot_ctrl

Parametrised boot controller between the host byte link and the core. It loads a length-prefixed instruction image and a data image into instruction memory and the data cache, then verifies a checksum. It then runs the core and streams a variable-length result region back over the link. Successor to the fixed-protocol loader: word width, memory depths and result size are generic, and it adds image lengths, checksumming, error reporting and a write-backpressure path.

## Interface
- DATAW, 32: word width; multiple of 8; BPW = DATAW/8 bytes per word
- INST_MEM_ADDRW, 12: instruction memory address width
- CACHE_ADDRW, 16: data memory address width
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  byte accepted when rx_valid&rx_ready
- tx_data  out  8  byte to host
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  byte consumed when tx_valid&tx_ready
- cache_init_done  in  1  data memory ready after reset (level)
- instr_we  out  1  instruction write strobe (1 cycle)
- instr_addr  out  INST_MEM_ADDRW  instruction word address
- instr_data  out  DATAW  instruction word
- cache_we  out  1  data write request, held until cache_wready
- cache_re  out  1  data read request (1 cycle)
- cache_addr  out  CACHE_ADDRW  data word address
- cache_wdata  out  DATAW  data write word
- cache_wready  in  1  write accepted this cycle
- cache_rdata  in  DATAW  read word
- cache_valid  in  1  cache_rdata valid (variable latency ≥1)
- core_exec_done  in  1  core finished (level or pulse)
- result_words  in  CACHE_ADDRW+1  words to dump, sampled when core_exec_done seen
- core_clk_en  out  1  core clock enable
- err  out  1  sticky protocol/checksum error

## Operation
- Reset values: every output 0; counters, checksum and state cleared; state INIT.
- INIT: wait cache_init_done → SEND_RDY (tx byte 0x99).
- RX_ICNT: 4 bytes, little-endian 32-bit N_I. N_I > 2^INST_MEM_ADDRW → SEND_ERR. N_I=0 → RX_DCNT.
- RX_IWORD: BPW bytes per word, LSB first. The cycle after the last byte, instr_we=1 with addr = word index 0..N_I-1. rx_ready stays high, so back-to-back bytes need no stall. After word N_I-1 → RX_DCNT.
- RX_DCNT: 4-byte N_D. N_D > 2^CACHE_ADDRW → SEND_ERR. N_D=0 → RX_CSUM.
- RX_DWORD: assemble as above, then assert cache_we/addr/wdata until cache_wready. rx_ready=0 while a write is pending.
- RX_CSUM: 1 byte. Compare with running sum mod 256 of all bytes received after 0x99 (count fields and payloads, excluding the checksum byte).
  - Match → SEND_ACK (0xaa).
  - Mismatch → SEND_ERR.
- RUN: core_clk_en=1 from the cycle after 0xaa is consumed. On core_exec_done=1: core_clk_en=0 the next cycle, latch result_words as R.
- DUMP: for i=0..R-1: cache_re pulse with addr i, wait cache_valid, capture word, send BPW bytes LSB first. R=0 → SEND_END directly.
- SEND_END (0x55) → DONE. Hold DONE until reset.
- SEND_ERR (0xee) → ERR. err=1 from entering SEND_ERR, sticky until reset.
- rx_ready=0 in every state except RX_*. Bytes arriving elsewhere stay pending on the link.
- core_exec_done outside RUN: ignored. cache_valid outside DUMP wait: ignored. cache_wready without cache_we: ignored.

## Timing
- All outputs registered. tx_valid/tx_data stay stable until tx_ready; the next byte may be presented the cycle after a handshake.
- Instruction load throughput: 1 byte/cycle sustained. Data load: BPW cycles + write stall per word.
- Dump latency per word: 1 (cache_re) + memory latency + ≥BPW tx cycles.
- core_clk_en is never 1 outside RUN. Exactly 0 cycles of overlap between core_clk_en and any instr_we/cache_we/cache_re.
- Async reset mid-operation: all outputs 0 immediately. A partially received word is discarded; no write strobe is emitted.
- Counter widths: word index INST_MEM_ADDRW+1 / CACHE_ADDRW+1 bits. The full-depth image (N = 2^ADDRW) is legal; address wraps never occur.

## Test plan
- Nominal, DATAW=32: N_I=2 (0x00000013, 0x00100093), N_D=1 (0xdeadbeef), correct checksum → tx 0x99, 0xaa. instr writes at 0,1; cache write at 0; core_clk_en=1. Then core_exec_done with result_words=1 and rdata 0x11223344 → tx 44,33,22,11,0x55.
- Checksum off by one → tx 0x99, 0xee; err=1; no core_clk_en; further rx bytes not accepted.
- N_I=0, N_D=0, checksum 0x00 → 0xaa. With result_words=0 → immediate 0x55.
- cache_wready delayed 5 cycles per word, tx_ready toggling every other cycle → no byte lost or duplicated; addresses sequential.
- N_I = 2^INST_MEM_ADDRW+1 → 0xee right after the count; zero instr_we pulses.
- Reset asserted mid RX_IWORD (2 of 4 bytes) → outputs 0 at once; after release, a full reload succeeds.
